aes_iter_ctrl: RTL and testbench
================================

// Module: aes_iter_ctrl
// PURPOSE
//  Sequences one combinational AES-128 round datapath iteratively over a full encryption.
//  Datapath: SubBytes, ShiftRows, optional MixColumns, AddRoundKey, plus key-schedule step.
//  Accepts plaintext and cipher key over a valid/ready handshake.
//  Performs the initial AddRoundKey, then loops state and round key through the datapath
//  for NUM_ROUNDS cycles. Presents the ciphertext on a valid/ready output.
// PARAMETERS
//  NUM_ROUNDS  10   rounds per block (AES-128); last round skips MixColumns
//  ROUND_W     4    width of round counter / dp_round
// PORTS
//  clk          in   1        single clock, all flops rising-edge
//  rst_n        in   1        reset, asynchronous assert, active-low
//  flush        in   1        sync abort; any state -> IDLE next edge
//  in_valid     in   1        plaintext+key offered
//  in_ready     out  1        block can accept (IDLE only)
//  in_data      in   128      plaintext
//  in_key       in   128      cipher key
//  out_valid    out  1        ciphertext valid
//  out_ready    in   1        consumer accepts ciphertext
//  out_data     out  128      ciphertext (= state_r)
//  busy         out  1        high in RUN or DONE
//  dp_round     out  ROUND_W  current round 1..NUM_ROUNDS to datapath/key step (rcon index)
//  dp_last      out  1        high when dp_round==NUM_ROUNDS (datapath bypasses MixColumns)
//  dp_data      out  128      state_r fed to datapath
//  dp_key       out  128      previous round key key_r fed to key step
//  dp_out_data  in   128      datapath result for dp_round (combinational from dp_*)
//  dp_out_key   in   128      round key for dp_round
// BEHAVIOUR
//  Reset (rst_n=0): FSM=IDLE, rnd=0, state_r=0, key_r=0.
//   Outputs after reset: in_ready=1, out_valid=0, busy=0.
//  FSM states: IDLE, RUN, DONE (2-bit encoding).
//  IDLE: in_ready=1.
//   On in_valid: state_r<=in_data^in_key, key_r<=in_key, rnd<=1, ->RUN.
//  RUN: each edge state_r<=dp_out_data, key_r<=dp_out_key, rnd<=rnd+1.
//   When rnd==NUM_ROUNDS: rnd<=0 and ->DONE.
//   in_ready=0 throughout.
//  DONE: out_valid=1 and out_data=state_r, both held stable until out_ready.
//   On out_valid&&out_ready: ->IDLE.
//   Input is not accepted in DONE.
//  Latency: out_valid rises exactly NUM_ROUNDS edges after the accepting edge.
//   Minimum spacing between accepts is NUM_ROUNDS+2 cycles.
//  dp_* outputs are driven from registers only, so there is no comb path in->out.
//   dp_round=rnd and dp_data=state_r in every state.
//   Datapath results are ignored outside RUN.
//  Counter: rnd never exceeds NUM_ROUNDS; a value outside 0..NUM_ROUNDS forces ->IDLE.
//  flush has priority over every transition.
//   Next edge: FSM=IDLE, rnd=0, out_valid=0; state_r/key_r are cleared to 0.
//   A flush coinciding with in_valid in IDLE drops that input (no accept).
//  Async reset mid-block aborts the operation immediately; no partial output is produced.
//  in_data/in_key are sampled only on the accepting edge and may change afterwards.
// STRUCTURE
//  Shared package aes_ctrl_pkg holds:
//   FSM state typedef (IDLE/RUN/DONE), NUM_ROUNDS default, AES block width 128.
//  No sub-module: FSM, counter and the two 128-bit registers live in this block.
//   The round datapath and key step are instantiated beside it by the parent.
// TESTING
//  1 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff
//    -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
//    out_valid exactly 10 edges after accept.
//  2 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//    -> ct 3925841d02dc09fbdc118597196a0b32.
//    key_r after round 1 = a0fafe1788542cb123a339392a6c7605.
//  3 Backpressure: hold out_ready=0 for 7 cycles.
//    out_valid/out_data stay stable; in_ready=0; in_valid pulses are ignored.
//  4 flush asserted at rnd=5 -> next edge IDLE, in_ready=1, out_valid=0.
//    A subsequent block (vector 1) still gives the correct ct.
//  5 rst_n dropped mid-RUN (rnd=3) -> outputs go to reset values asynchronously.
//    Release, then back-to-back vectors 1 and 2 with out_ready=1 give correct ct.
//    Accept spacing is 12 cycles.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the iterative AES-128 controller: block width,
// default round count and the controller state encoding.
package aes_ctrl_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int NUM_ROUNDS_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

endpackage

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 sequencer: owns the state/round-key registers and the round
// counter, and drives an external combinational round datapath and key step.
module aes_iter_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int ROUND_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic [AES_BLOCK_W-1:0] in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy,
  output logic [ROUND_W-1:0]     dp_round,
  output logic                   dp_last,
  output logic [AES_BLOCK_W-1:0] dp_data,
  output logic [AES_BLOCK_W-1:0] dp_key,
  input  logic [AES_BLOCK_W-1:0] dp_out_data,
  input  logic [AES_BLOCK_W-1:0] dp_out_key
);

  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS);

  aes_state_e               fsm_q, fsm_d;
  logic [ROUND_W-1:0]       rnd_q, rnd_d;
  logic [AES_BLOCK_W-1:0]   state_r, state_nx;
  logic [AES_BLOCK_W-1:0]   key_r, key_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= '0;
      state_r <= '0;
      key_r   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_r <= state_nx;
      key_r   <= key_nx;
    end
  end

  // flush outranks everything; an out-of-range counter is treated as corruption
  always_comb begin
    fsm_d    = fsm_q;
    rnd_d    = rnd_q;
    state_nx = state_r;
    key_nx   = key_r;
    if (flush) begin
      fsm_d    = ST_IDLE;
      rnd_d    = '0;
      state_nx = '0;
      key_nx   = '0;
    end else if (rnd_q > LAST_RND) begin
      fsm_d = ST_IDLE;
      rnd_d = '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_nx = in_data ^ in_key;
            key_nx   = in_key;
            rnd_d    = ROUND_W'(1);
            fsm_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          state_nx = dp_out_data;
          key_nx   = dp_out_key;
          if (rnd_q == LAST_RND) begin
            rnd_d = '0;
            fsm_d = ST_DONE;
          end else begin
            rnd_d = rnd_q + ROUND_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) fsm_d = ST_IDLE;
        end
        default: begin
          fsm_d = ST_IDLE;
          rnd_d = '0;
        end
      endcase
    end
  end

  // Every output is a decode of registers, keeping the datapath loop free of comb paths
  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign out_data  = state_r;
  assign dp_round  = rnd_q;
  assign dp_last   = (rnd_q == LAST_RND);
  assign dp_data   = state_r;
  assign dp_key    = key_r;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl with a behavioural AES round and key step
// standing in for the parent's datapath; checks against FIPS-197 vectors.
module tb_aes_iter_ctrl;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] S0B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_ready, out_valid, busy, dp_last;
  logic [127:0] out_data, dp_data, dp_key, dp_out_data, dp_out_key;
  logic [3:0]   dp_round;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_iter_ctrl #(.NUM_ROUNDS(10), .ROUND_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dp_round(dp_round), .dp_last(dp_last),
    .dp_data(dp_data), .dp_key(dp_key),
    .dp_out_data(dp_out_data), .dp_out_key(dp_out_key)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] y, input int n);
    logic [15:0] t;
    t = {y, y} << n;
    return t[15:8];
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h01;
    for (int i = 0; i < 254; i++) y = gf_mul(y, x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rnd);
    logic [7:0]  rc;
    logic [31:0] w0, w1, w2, w3, rot, tmp, n0, n1, n2, n3;
    rc = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rc = gf_mul(rc, 8'h02);
    {w0, w1, w2, w3} = k;
    rot = {w3[23:0], w3[31:24]};
    tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0 = w0 ^ tmp;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   s [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
        s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
        s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
        s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
        s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res ^ rk;
  endfunction

  assign dp_out_key  = key_step(dp_key, dp_round);
  assign dp_out_data = aes_round(dp_data, dp_out_key, dp_last);

  // Offers one block once in_ready is up; scrambles inputs after the accepting edge
  task automatic accept(input logic [127:0] d, input logic [127:0] k);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_wait: in_ready got %b want 1", in_ready);
    end
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_key   = ~k;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL out_valid_timeout: got %b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (dp_key !== 128'h0) begin errors++; $display("[TB] FAIL reset_dp_key: got %h want 0", dp_key); end
    checks++; if (dp_round !== 4'd0) begin errors++; $display("[TB] FAIL reset_dp_round: got %0d want 0", dp_round); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_c1();
    int n;
    $display("[TB] FIPS-197 C.1 vector");
    out_ready = 1'b1;
    accept(P1, K1);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL c1_busy: got %b want 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL c1_in_ready: got %b want 0", in_ready); end
    wait_out(n);
    checks++; if (n != 10) begin errors++; $display("[TB] FAIL c1_latency: got %0d want 10", n); end
    checks++; if (out_data !== C1) begin errors++; $display("[TB] FAIL c1_ct: got %h want %h", out_data, C1); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL c1_return_idle: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_fips_b();
    int n;
    $display("[TB] FIPS-197 B vector");
    out_ready = 1'b1;
    accept(P2, K2);
    checks++; if (dp_round !== 4'd1) begin errors++; $display("[TB] FAIL b_round1: got %0d want 1", dp_round); end
    checks++; if (dp_data !== S0B) begin errors++; $display("[TB] FAIL b_initial_ark: got %h want %h", dp_data, S0B); end
    checks++; if (dp_key !== K2) begin errors++; $display("[TB] FAIL b_key0: got %h want %h", dp_key, K2); end
    @(posedge clk); #1;
    checks++; if (dp_key !== RK1) begin errors++; $display("[TB] FAIL b_key1: got %h want %h", dp_key, RK1); end
    wait_out(n);
    checks++; if (n != 9) begin errors++; $display("[TB] FAIL b_latency: got %0d want 9", n); end
    checks++; if (out_data !== C2) begin errors++; $display("[TB] FAIL b_ct: got %h want %h", out_data, C2); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    $display("[TB] output backpressure");
    out_ready = 1'b0;
    accept(P1, K1);
    wait_out(n);
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = P2;
      in_key   = K2;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== C1) begin
        errors++; $display("[TB] FAIL bp_hold[%0d]: valid %b data %h want 1 %h", i, out_valid, out_data, C1);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: valid %b ready %b busy %b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_flush();
    int n;
    $display("[TB] flush mid-run");
    out_ready = 1'b1;
    accept(P2, K2);
    n = 0;
    while (dp_round !== 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (dp_round !== 4'd5) begin errors++; $display("[TB] FAIL flush_reach_rnd5: got %0d want 5", dp_round); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_idle: ready %b valid %b busy %b want 1 0 0", in_ready, out_valid, busy);
    end
    checks++; if (dp_round !== 4'd0 || dp_data !== 128'h0 || dp_key !== 128'h0) begin
      errors++; $display("[TB] FAIL flush_clear: rnd %0d data %h key %h want 0", dp_round, dp_data, dp_key);
    end
    in_valid = 1'b1; in_data = P1; in_key = K1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_drops_input: busy %b want 0", busy); end
    accept(P1, K1);
    wait_out(n);
    checks++; if (out_data !== C1) begin errors++; $display("[TB] FAIL flush_next_ct: got %h want %h", out_data, C1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int n;
    $display("[TB] async reset mid-run");
    accept(P2, K2);
    n = 0;
    while (dp_round !== 4'd3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (dp_round !== 4'd3) begin errors++; $display("[TB] FAIL rst_reach_rnd3: got %0d want 3", dp_round); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_async: ready %b valid %b busy %b want 1 0 0", in_ready, out_valid, busy);
    end
    checks++; if (dp_round !== 4'd0 || out_data !== 128'h0) begin
      errors++; $display("[TB] FAIL rst_async_regs: rnd %0d data %h want 0", dp_round, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int accepts, outs, n;
    int acc_cyc [2];
    logic acc;
    logic [127:0] exp_ct;
    $display("[TB] back-to-back blocks");
    accepts = 0; outs = 0; n = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    out_ready = 1'b1;
    in_data = P1; in_key = K1; in_valid = 1'b1;
    while (outs < 2 && n < 60) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      if (acc) begin
        if (accepts < 2) acc_cyc[accepts] = cyc;
        accepts++;
        if (accepts == 1) begin in_data = P2; in_key = K2; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        exp_ct = (outs == 0) ? C1 : C2;
        checks++; if (out_data !== exp_ct) begin
          errors++; $display("[TB] FAIL b2b_ct[%0d]: got %h want %h", outs, out_data, exp_ct);
        end
        outs++;
      end
    end
    in_valid = 1'b0;
    checks++; if (outs != 2 || accepts != 2) begin
      errors++; $display("[TB] FAIL b2b_count: outs %0d accepts %0d want 2 2", outs, accepts);
    end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 12) begin
      errors++; $display("[TB] FAIL b2b_spacing: got %0d want 12", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_flush();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
